// File: rtl/lane_router_pkg.sv
// Shared types and helpers for the lane router.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
// Contents: lr_op_e operation codes and lane_lsb(), which gives the low bit of lane k.
package lane_router_pkg;

  typedef enum logic [2:0] {
    LR_PASS      = 3'd0,
    LR_INSERT    = 3'd1,
    LR_EXTRACT   = 3'd2,
    LR_BROADCAST = 3'd3,
    LR_GATHER    = 3'd4
  } lr_op_e;

  // Lane k of a packed vector occupies bits [lane_lsb(k, w) +: w].
  function automatic int lane_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/lane_router_gather.sv
// Gather accumulator: collects LANES scalars and releases them as one vector.
// Latency: state updates on the clock edge; final_beat and gather_vec are combinational.
// Backpressure: none internally; the parent only pulses beat/abort on accepted beats.
// Ports: clk, rst (async, active-high); beat/abort are accepted-beat strobes;
//   scalar is the incoming lane value; final_beat is high when the next beat completes the vector;
//   gather_vec is the completed vector (valid while final_beat); busy is high while a gather is partial.
// Only instantiated when LANE_ROUTER_GATHER_EN is defined.
module lane_router_gather
  import lane_router_pkg::*;
#(
  parameter int LANES = 4,
  parameter int W     = 32,
  localparam int LW   = $clog2(LANES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               beat,
  input  logic               abort,
  input  logic [W-1:0]       scalar,
  output logic               final_beat,
  output logic [LANES*W-1:0] gather_vec,
  output logic               busy
);

  localparam logic [LW-1:0] LAST = LW'(LANES - 1);

  logic [LW-1:0]          gcnt;
  // The top lane is never stored: the final beat supplies it directly.
  logic [(LANES-1)*W-1:0] buffer;

  assign final_beat = (gcnt == LAST);
  assign gather_vec = {scalar, buffer};
  assign busy       = (gcnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt   <= '0;
      buffer <= '0;
    end else if (abort || (beat && final_beat)) begin
      // Completing or abandoning a gather both leave the accumulator empty.
      gcnt   <= '0;
      buffer <= '0;
    end else if (beat) begin
      gcnt <= gcnt + LW'(1);
      for (int k = 0; k < LANES - 1; k++) begin
        if (k == int'(gcnt)) begin
          buffer[lane_lsb(k, W) +: W] <= scalar;
        end
      end
    end
  end

endmodule

// File: rtl/lane_router_pipe.sv
// Scalar/vector lane router: pass, insert, extract, broadcast and (optionally) gather.
// Latency: 1 cycle from accepted beat to out_valid (single output register).
// Backpressure: in_ready = !out_valid || out_ready; the result is held stable while stalled.
// Ports: clk, rst (async, active-high); in_valid/in_ready request handshake with op, lane,
//   scalar and vector_in; out_valid/out_ready result handshake with vector_out;
//   gather_busy is high while a partial gather is held.
// Build option: define LANE_ROUTER_GATHER_EN to enable GATHER (op 4); otherwise op 4 is PASS.
module lane_router_pipe
  import lane_router_pkg::*;
#(
  parameter int LANES = 4,
  parameter int W     = 32,
  localparam int LW   = $clog2(LANES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [LW-1:0]      lane,
  input  logic [W-1:0]       scalar,
  input  logic [LANES*W-1:0] vector_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] vector_out,
  output logic               gather_busy
);

  lr_op_e             op_e;
  logic               accept;
  logic               produce;
  logic [LANES*W-1:0] result;

  assign op_e     = lr_op_e'(op);
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef LANE_ROUTER_GATHER_EN
  logic               is_gather;
  logic               final_beat;
  logic [LANES*W-1:0] gather_vec;

  assign is_gather = (op_e == LR_GATHER);

  // Any other accepted op abandons a partial gather.
  lane_router_gather #(
    .LANES (LANES),
    .W     (W)
  ) u_gather (
    .clk        (clk),
    .rst        (rst),
    .beat       (accept && is_gather),
    .abort      (accept && !is_gather),
    .scalar     (scalar),
    .final_beat (final_beat),
    .gather_vec (gather_vec),
    .busy       (gather_busy)
  );
`else
  assign gather_busy = 1'b0;
`endif

  // Lane selection. An out-of-range lane never matches k, so INSERT degrades
  // to PASS and EXTRACT to all zeros without an explicit range check.
  always_comb begin
    result  = vector_in;
    produce = 1'b1;
    case (op_e)
      LR_INSERT: begin
        for (int k = 0; k < LANES; k++) begin
          if (k == int'(lane)) begin
            result[lane_lsb(k, W) +: W] = scalar;
          end
        end
      end
      LR_EXTRACT: begin
        result = '0;
        for (int k = 0; k < LANES; k++) begin
          if (k == int'(lane)) begin
            result[W-1:0] = vector_in[lane_lsb(k, W) +: W];
          end
        end
      end
      LR_BROADCAST: begin
        for (int k = 0; k < LANES; k++) begin
          result[lane_lsb(k, W) +: W] = scalar;
        end
      end
`ifdef LANE_ROUTER_GATHER_EN
      LR_GATHER: begin
        // Only the beat that completes the vector loads the output register.
        result  = gather_vec;
        produce = final_beat;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      vector_out <= '0;
    end else if (accept && produce) begin
      out_valid  <= 1'b1;
      vector_out <= result;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lane_router_pipe.sv
// Self-checking bench for lane_router_pipe (LANES=4, W=32): directed scenarios plus random traffic
// against a lane-array / queue reference model. Honours LANE_ROUTER_GATHER_EN like the design.
module tb_lane_router_pipe;

  localparam int LANES = 4;
  localparam int W     = 32;
  localparam int VW    = LANES * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    op = 3'd0;
  logic [1:0]    lane = 2'd0;
  logic [W-1:0]  scalar = '0;
  logic [VW-1:0] vector_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [VW-1:0] vector_out;
  logic          gather_busy;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic          m_valid = 1'b0;
  logic [VW-1:0] m_out = '0;
  logic [W-1:0]  gq[$];
  logic          exp_ready;
  logic          seen_ready;

  localparam logic [VW-1:0] GV = {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000};

  lane_router_pipe #(.LANES(LANES), .W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .lane        (lane),
    .scalar      (scalar),
    .vector_in   (vector_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .vector_out  (vector_out),
    .gather_busy (gather_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] ref_route(input logic [2:0] o, input int l,
                                              input logic [W-1:0] s, input logic [VW-1:0] vi);
    logic [W-1:0]  lv[LANES];
    logic [W-1:0]  e;
    logic [VW-1:0] r;
    for (int k = 0; k < LANES; k++) lv[k] = vi[k*W +: W];
    case (o)
      3'd1: if (l < LANES) lv[l] = s;
      3'd2: begin
        e = (l < LANES) ? lv[l] : '0;
        for (int k = 0; k < LANES; k++) lv[k] = '0;
        lv[0] = e;
      end
      3'd3: for (int k = 0; k < LANES; k++) lv[k] = s;
      default: ;
    endcase
    for (int k = 0; k < LANES; k++) r[k*W +: W] = lv[k];
    return r;
  endfunction

  task automatic model_update(input logic v, input logic [2:0] o, input logic [1:0] l,
                              input logic [W-1:0] s, input logic [VW-1:0] vi, input logic ordy);
    logic gathered;
    gathered = 1'b0;
    if (v && exp_ready) begin
`ifdef LANE_ROUTER_GATHER_EN
      if (o == 3'd4) begin
        gathered = 1'b1;
        gq.push_back(s);
        if (gq.size() == LANES) begin
          for (int k = 0; k < LANES; k++) m_out[k*W +: W] = gq[k];
          gq.delete();
          m_valid = 1'b1;
        end else if (ordy) begin
          m_valid = 1'b0;
        end
      end else begin
        gq.delete();
      end
`endif
      if (!gathered) begin
        m_out   = ref_route(o, int'(l), s, vi);
        m_valid = 1'b1;
      end
    end else if (ordy) begin
      m_valid = 1'b0;
    end
  endtask

  // One clock of stimulus: drive after the falling edge, note in_ready, then settle past the rise.
  task automatic step(input logic v, input logic [2:0] o, input logic [1:0] l,
                      input logic [W-1:0] s, input logic [VW-1:0] vi, input logic ordy);
    @(negedge clk);
    in_valid = v; op = o; lane = l; scalar = s; vector_in = vi; out_ready = ordy;
    #1;
    seen_ready = in_ready;
    exp_ready  = !m_valid || ordy;
    @(posedge clk);
    model_update(v, o, l, s, vi, ordy);
    #1;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_out   = '0;
    gq.delete();
  endtask

  task automatic test_reset();
    #3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
    total++; if (vector_out !== '0) begin bad++; $display("FAIL reset_vec got=%h want=0", vector_out); end
    total++; if (gather_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", gather_busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_insert();
    logic [VW-1:0] want;
    want = {32'hD, 32'hDEADBEEF, 32'hB, 32'hA};
    step(1'b1, 3'd1, 2'd2, 32'hDEADBEEF, {32'hD, 32'hC, 32'hB, 32'hA}, 1'b1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL insert_valid got=%0b want=1", out_valid); end
    total++; if (vector_out !== want) begin bad++; $display("FAIL insert_vec got=%h want=%h", vector_out, want); end
  endtask

  task automatic test_extract_broadcast();
    logic [VW-1:0] want;
    want = {32'h0, 32'h0, 32'h0, 32'h44};
    step(1'b1, 3'd2, 2'd3, 32'h0, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b1);
    total++; if (vector_out !== want) begin bad++; $display("FAIL extract_vec got=%h want=%h", vector_out, want); end
    want = {32'h5, 32'h5, 32'h5, 32'h5};
    step(1'b1, 3'd3, 2'd1, 32'h5, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b1);
    total++; if (vector_out !== want) begin bad++; $display("FAIL broadcast_vec got=%h want=%h", vector_out, want); end
  endtask

  // Four back-to-back op-4 beats carrying first..first+3.
  task automatic gather4(input logic [W-1:0] first, input string name);
    logic [VW-1:0] want;
    for (int b = 0; b < LANES; b++) begin
      step(1'b1, 3'd4, 2'(b), first + W'(b), GV, 1'b1);
`ifdef LANE_ROUTER_GATHER_EN
      if (b < LANES - 1) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_beat%0d_valid got=%0b want=0", name, b, out_valid); end
        total++; if (gather_busy !== 1'b1) begin bad++; $display("FAIL %s_beat%0d_busy got=%0b want=1", name, b, gather_busy); end
      end
`else
      total++; if (vector_out !== GV) begin bad++; $display("FAIL %s_pass%0d_vec got=%h want=%h", name, b, vector_out, GV); end
`endif
    end
`ifdef LANE_ROUTER_GATHER_EN
    for (int k = 0; k < LANES; k++) want[k*W +: W] = first + W'(k);
`else
    want = GV;
`endif
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL %s_final_valid got=%0b want=1", name, out_valid); end
    total++; if (vector_out !== want) begin bad++; $display("FAIL %s_final_vec got=%h want=%h", name, vector_out, want); end
    total++; if (gather_busy !== 1'b0) begin bad++; $display("FAIL %s_final_busy got=%0b want=0", name, gather_busy); end
  endtask

  task automatic test_gather();
    gather4(32'd1, "gather");
  endtask

  task automatic test_gather_abort();
    logic [VW-1:0] nines;
    nines = {32'h9, 32'h9, 32'h9, 32'h9};
    step(1'b1, 3'd4, 2'd0, 32'd1, GV, 1'b1);
    step(1'b1, 3'd4, 2'd0, 32'd2, GV, 1'b1);
    step(1'b1, 3'd0, 2'd0, 32'd0, nines, 1'b1);
    total++; if (vector_out !== nines) begin bad++; $display("FAIL abort_vec got=%h want=%h", vector_out, nines); end
    total++; if (gather_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b want=0", gather_busy); end
    gather4(32'd5, "regather");
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] x, y;
    x = {32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000};
    y = {32'h2222_0003, 32'h2222_0002, 32'h2222_0001, 32'h2222_0000};
    step(1'b1, 3'd0, 2'd0, 32'd0, x, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 3'd0, 2'd0, 32'd0, y, 1'b0);
      total++; if (seen_ready !== 1'b0) begin bad++; $display("FAIL stall%0d_ready got=%0b want=0", c, seen_ready); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall%0d_valid got=%0b want=1", c, out_valid); end
      total++; if (vector_out !== x) begin bad++; $display("FAIL stall%0d_vec got=%h want=%h", c, vector_out, x); end
    end
    step(1'b1, 3'd0, 2'd0, 32'd0, y, 1'b1);
    total++; if (seen_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%0b want=1", seen_ready); end
    total++; if (vector_out !== y) begin bad++; $display("FAIL release_vec got=%h want=%h", vector_out, y); end
    step(1'b0, 3'd0, 2'd0, 32'd0, x, 1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL no_dup_valid got=%0b want=0", out_valid); end
  endtask

  task automatic async_reset(input string name);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_valid got=%0b want=0", name, out_valid); end
    total++; if (vector_out !== '0) begin bad++; $display("FAIL %s_vec got=%h want=0", name, vector_out); end
    total++; if (gather_busy !== 1'b0) begin bad++; $display("FAIL %s_busy got=%0b want=0", name, gather_busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_ready got=%0b want=1", name, in_ready); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_gather();
    step(1'b1, 3'd4, 2'd0, 32'd1, GV, 1'b1);
    step(1'b1, 3'd4, 2'd0, 32'd2, GV, 1'b0);
`ifdef LANE_ROUTER_GATHER_EN
    total++; if (gather_busy !== 1'b1) begin bad++; $display("FAIL pre_reset_busy got=%0b want=1", gather_busy); end
`endif
    async_reset("rst_gather");
    step(1'b1, 3'd0, 2'd0, 32'd0, {32'h3, 32'h3, 32'h3, 32'h3}, 1'b0);
    step(1'b0, 3'd0, 2'd0, 32'd0, '0, 1'b0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_held got=%0b want=1", out_valid); end
    async_reset("rst_held");
    gather4(32'd10, "post_reset");
  endtask

  task automatic test_random();
    logic [2:0]    o;
    logic [VW-1:0] v;
    for (int c = 0; c < 600; c++) begin
      o = ($urandom_range(0, 2) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
      for (int k = 0; k < LANES; k++) v[k*W +: W] = $urandom;
      step($urandom_range(0, 3) != 0, o, 2'($urandom_range(0, 3)), $urandom, v,
           $urandom_range(0, 9) < 7);
      total++; if (seen_ready !== exp_ready) begin bad++; $display("FAIL rand%0d_ready got=%0b want=%0b", c, seen_ready, exp_ready); end
      total++; if (out_valid !== m_valid) begin bad++; $display("FAIL rand%0d_valid got=%0b want=%0b", c, out_valid, m_valid); end
      if (m_valid) begin
        total++; if (vector_out !== m_out) begin bad++; $display("FAIL rand%0d_vec got=%h want=%h", c, vector_out, m_out); end
      end
      total++; if (gather_busy !== (gq.size() != 0)) begin bad++; $display("FAIL rand%0d_busy got=%0b want=%0b", c, gather_busy, gq.size() != 0); end
    end
  endtask

  initial begin
    test_reset();
    test_insert();
    test_extract_broadcast();
    test_gather();
    test_gather_abort();
    test_back_to_back();
    test_reset_mid_gather();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
